// File: rtl/pl_reg_mw_elastic_pkg.sv
// Shared pipeline definitions for the M->W elastic pipeline register:
// result-source encodings and the packed payload width.
package pl_reg_mw_elastic_pkg;

  // Write-back result selection carried alongside each beat.
  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_LOAD = 2'b01,
    RESULT_PC4  = 2'b10
  } result_src_e;

  localparam int RD_WIDTH = 5;

  // Packed entry: reg_write, result_src, alu_result, read_data, rd, pc_plus4.
  function automatic int payload_width(input int address_width, input int data_width);
    return 1 + 2 + 2 * data_width + RD_WIDTH + address_width;
  endfunction

  localparam int PAYLOAD_WIDTH_DEFAULT = payload_width(32, 32);

endpackage

// File: rtl/pl_reg_mw_elastic_if.sv
// M-stage input and W-stage output bundle of the elastic pipeline register.
// Handshake: a beat moves across a side on a rising clk edge when that side's
// valid and ready are both high; valid never depends on ready, and ready on
// the input side depends only on the stored occupancy.
interface pl_reg_mw_elastic_if
  import pl_reg_mw_elastic_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 2
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  // M-stage side
  logic                     in_valid;
  logic                     in_ready;
  logic                     reg_write_m_i;
  logic [1:0]               result_src_m_i;
  logic [DATA_WIDTH-1:0]    alu_result_m_i;
  logic [DATA_WIDTH-1:0]    read_data_m_i;
  logic [RD_WIDTH-1:0]      rd_m_i;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_m_i;

  // W-stage side
  logic                     out_valid;
  logic                     out_ready;
  logic                     reg_write_w_o;
  logic [1:0]               result_src_w_o;
  logic [DATA_WIDTH-1:0]    alu_result_w_o;
  logic [DATA_WIDTH-1:0]    read_data_w_o;
  logic [RD_WIDTH-1:0]      rd_w_o;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_w_o;

  logic [CW-1:0]            count;

  // Buffer side
  modport slave (
    input  in_valid, reg_write_m_i, result_src_m_i, alu_result_m_i,
           read_data_m_i, rd_m_i, pc_plus4_m_i, out_ready,
    output in_ready, out_valid, reg_write_w_o, result_src_w_o, alu_result_w_o,
           read_data_w_o, rd_w_o, pc_plus4_w_o, count
  );

  // Environment side (drives M stage, consumes W stage)
  modport master (
    output in_valid, reg_write_m_i, result_src_m_i, alu_result_m_i,
           read_data_m_i, rd_m_i, pc_plus4_m_i, out_ready,
    input  in_ready, out_valid, reg_write_w_o, result_src_w_o, alu_result_w_o,
           read_data_w_o, rd_w_o, pc_plus4_w_o, count
  );

endinterface

// File: rtl/pl_fifo_ctrl.sv
// Pointer and occupancy control for a power-of-two circular buffer.
// Flush wins over push and pop; push when full and pop when empty are ignored.
module pl_fifo_ctrl #(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr,
  output logic [AW-1:0] o_wr_ptr,
  output logic [AW-1:0] o_rd_ptr,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  assign w_push  = i_push && !o_full  && !i_clr;
  assign w_pop   = i_pop  && !o_empty && !i_clr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

endmodule

// File: rtl/pl_reg_mw_elastic.sv
// Elastic M->W pipeline register: a small FIFO of packed M-stage beats.
// Outputs come only from stored state, so there is no in-to-out path and a
// beat written into an empty buffer appears one edge later.
module pl_reg_mw_elastic
  import pl_reg_mw_elastic_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 2
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 clr,
  pl_reg_mw_elastic_if.slave  bus
);

  localparam int PW = payload_width(ADDRESS_WIDTH, DATA_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]            w_wr_ptr;
  logic [AW-1:0]            w_rd_ptr;
  logic [CW-1:0]            w_count;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_reg_write_in;
  logic [PW-1:0]            w_din;
  logic [PW-1:0]            w_head;

  logic                     w_h_reg_write;
  logic [1:0]               w_h_result_src;
  logic [DATA_WIDTH-1:0]    w_h_alu_result;
  logic [DATA_WIDTH-1:0]    w_h_read_data;
  logic [RD_WIDTH-1:0]      w_h_rd;
  logic [ADDRESS_WIDTH-1:0] w_h_pc_plus4;

  // Storage is not reset: entries are invisible until pushed.
  logic [PW-1:0]            r_mem [DEPTH];

  assign w_push = bus.in_valid  && !w_full  && !clr;
  assign w_pop  = bus.out_ready && !w_empty && !clr;

  pl_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_clr    (clr),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Writes to x0 are architecturally discarded, so drop reg_write at entry.
  assign w_reg_write_in = bus.reg_write_m_i && (bus.rd_m_i != '0);

  assign w_din = {w_reg_write_in, bus.result_src_m_i, bus.alu_result_m_i,
                  bus.read_data_m_i, bus.rd_m_i, bus.pc_plus4_m_i};

  // Store the packed beat at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_ptr] <= w_din;
  end

  assign w_head = r_mem[w_rd_ptr];

  assign {w_h_reg_write, w_h_result_src, w_h_alu_result,
          w_h_read_data, w_h_rd, w_h_pc_plus4} = w_head;

  // Present the head entry, forced to zero whenever nothing is buffered.
  always_comb begin
    bus.reg_write_w_o  = 1'b0;
    bus.result_src_w_o = '0;
    bus.alu_result_w_o = '0;
    bus.read_data_w_o  = '0;
    bus.rd_w_o         = '0;
    bus.pc_plus4_w_o   = '0;
    if (!w_empty) begin
      bus.reg_write_w_o  = w_h_reg_write;
      bus.result_src_w_o = w_h_result_src;
      bus.alu_result_w_o = w_h_alu_result;
      bus.read_data_w_o  = w_h_read_data;
      bus.rd_w_o         = w_h_rd;
      bus.pc_plus4_w_o   = w_h_pc_plus4;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.count     = w_count;

endmodule
